fir_alu: RTL and testbench

Arithmetic unit of the FIR core datapath: a signed 16×16 multiplier, a 32-bit adder and a 32-bit accumulator sharing one registered 32-bit output. The FIR controller drives one sample (`a`) and one coefficient (`b`) per cycle and selects the operation via `select`. Every operation is registered with one-cycle latency. The accumulator supports multiply-accumulate tap summation.

---
 rtl/fir_alu.sv | 72 +++++++
 tb/tb_fir_alu.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/fir_alu.sv
// Arithmetic unit for the FIR datapath. It provides signed add, signed 16x16 multiply,
// multiply-accumulate and clear. All results come from a single registered 32-bit output.
module fir_alu (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic [1:0]  select,
    output logic [31:0] result
);

    typedef enum logic [1:0] {
        OP_ADD = 2'b00,
        OP_MUL = 2'b01,
        OP_MAC = 2'b10,
        OP_CLR = 2'b11
    } op_e;

    op_e         op;
    logic [31:0] aExt;
    logic [31:0] bExt;
    logic [31:0] sum;
    logic [31:0] prod;
    logic [31:0] macSum;
    logic [31:0] acc_q;
    logic [31:0] acc_d;
    logic [31:0] result_q;
    logic [31:0] result_d;

    assign op = op_e'(select);

    // The low 32 bits of a product of sign-extended operands are the exact signed 16x16 product.
    assign aExt   = {{16{a[15]}}, a};
    assign bExt   = {{16{b[15]}}, b};
    assign sum    = aExt + bExt;
    assign prod   = aExt * bExt;
    assign macSum = acc_q + prod;

    always_comb begin
        acc_d    = acc_q;
        result_d = result_q;
        case (op)
            OP_ADD: result_d = sum;
            OP_MUL: result_d = prod;
            OP_MAC: begin
                acc_d    = macSum;
                result_d = macSum;
            end
            OP_CLR: begin
                acc_d    = '0;
                result_d = '0;
            end
            default: begin
                acc_d    = acc_q;
                result_d = result_q;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            acc_q    <= '0;
            result_q <= '0;
        end else begin
            acc_q    <= acc_d;
            result_q <= result_d;
        end
    end

    assign result = result_q;

endmodule

// File: tb/tb_fir_alu.sv
// Self-checking bench for fir_alu. It runs directed steps with constant expectations,
// followed by randomized streams that are checked against a behavioural arithmetic model.
module tb_fir_alu;

    logic        clk;
    logic        rst;
    logic [15:0] a;
    logic [15:0] b;
    logic [1:0]  select;
    logic [31:0] result;

    int testsRun    = 0;
    int testsFailed = 0;

    longint      modelAcc    = 0;
    logic [31:0] modelResult = '0;

    fir_alu dut (
        .clk    (clk),
        .rst    (rst),
        .a      (a),
        .b      (b),
        .select (select),
        .result (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: plain integer arithmetic, folded to 32 bits only where the hardware word wraps.
    task automatic applyStimulus(input logic rstN, input logic [15:0] aIn,
                                 input logic [15:0] bIn, input logic [1:0] selIn);
        longint sa;
        longint sb;
        sa = longint'($signed(aIn));
        sb = longint'($signed(bIn));
        rst    = rstN;
        a      = aIn;
        b      = bIn;
        select = selIn;
        if (!rstN) begin
            modelAcc    = 0;
            modelResult = '0;
        end else begin
            case (selIn)
                2'd0: modelResult = 32'(sa + sb);
                2'd1: modelResult = 32'(sa * sb);
                2'd2: begin
                    modelAcc    = (modelAcc + sa * sb) & 64'hFFFF_FFFF;
                    modelResult = 32'(modelAcc);
                end
                default: begin
                    modelAcc    = 0;
                    modelResult = '0;
                end
            endcase
        end
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] expected);
        testsRun++;
        assert (result === expected)
        else begin
            testsFailed++;
            $error("[TB] FAIL %s: result=%h expected=%h", tag, result, expected);
        end
    endtask

    initial begin
        rst = 1'b0; a = '0; b = '0; select = 2'b00;

        applyStimulus(1'b0, 16'd100, 16'd200, 2'b01);
        checkOutput("reset1", 32'd0);
        applyStimulus(1'b0, 16'd100, 16'd200, 2'b01);
        checkOutput("reset2", 32'd0);
        applyStimulus(1'b1, 16'd100, 16'd200, 2'b01);
        checkOutput("firstAfterReset", 32'd20000);

        applyStimulus(1'b1, 16'h7FFF, 16'h7FFF, 2'b00);
        checkOutput("addMax", 32'd65534);
        applyStimulus(1'b1, -16'sd5, 16'sd3, 2'b00);
        checkOutput("addNeg", 32'hFFFF_FFFE);
        applyStimulus(1'b1, -16'sd5, 16'sd3, 2'b00);
        checkOutput("addHold", 32'hFFFF_FFFE);

        applyStimulus(1'b1, 16'h8000, 16'h8000, 2'b01);
        checkOutput("mulMinMin", 32'h4000_0000);
        applyStimulus(1'b1, 16'h8000, 16'h7FFF, 2'b01);
        checkOutput("mulMinMax", 32'hC000_8000);
        applyStimulus(1'b1, 16'd0, 16'hBEEF, 2'b01);
        checkOutput("mulZero", 32'd0);

        applyStimulus(1'b1, 16'd9, 16'd9, 2'b11);
        checkOutput("clr", 32'd0);
        applyStimulus(1'b1, 16'd3, 16'd4, 2'b10);
        checkOutput("mac1", 32'd12);
        applyStimulus(1'b1, -16'sd2, 16'sd5, 2'b10);
        checkOutput("mac2", 32'd2);
        applyStimulus(1'b1, 16'd10, 16'd10, 2'b10);
        checkOutput("mac3", 32'd102);
        applyStimulus(1'b1, 16'd1, 16'd1, 2'b00);
        checkOutput("addBetweenMac", 32'd2);
        applyStimulus(1'b1, 16'd1, 16'd1, 2'b10);
        checkOutput("macRetained", 32'd103);
        applyStimulus(1'b1, 16'd1, 16'd1, 2'b10);
        checkOutput("macHold", 32'd104);

        applyStimulus(1'b1, 16'd0, 16'd0, 2'b11);
        checkOutput("clrWrap", 32'd0);
        applyStimulus(1'b1, 16'h7FFF, 16'h7FFF, 2'b10);
        checkOutput("preload1", 32'h3FFF_0001);
        applyStimulus(1'b1, 16'h7FFF, 16'h7FFF, 2'b10);
        checkOutput("preload2", 32'h7FFE_0002);
        applyStimulus(1'b1, 16'h8000, 16'h8000, 2'b10);
        checkOutput("wrapMac", 32'hBFFE_0002);

        applyStimulus(1'b1, 16'd0, 16'd0, 2'b11);
        checkOutput("clrEdge", 32'd0);
        applyStimulus(1'b1, 16'h8000, 16'h8000, 2'b10);
        applyStimulus(1'b1, 16'h7FFF, 16'h7FFF, 2'b10);
        applyStimulus(1'b1, 16'd2, 16'h7FFF, 2'b10);
        checkOutput("accMaxPos", 32'h7FFF_FFFF);
        applyStimulus(1'b1, 16'd1, 16'd1, 2'b10);
        checkOutput("accWrapSign", 32'h8000_0000);

        applyStimulus(1'b0, 16'd5, 16'd5, 2'b10);
        checkOutput("resetMidMac", 32'd0);
        applyStimulus(1'b1, 16'd1, 16'd1, 2'b10);
        checkOutput("macAfterReset", 32'd1);

        for (int i = 0; i < 64; i++) begin
            if (i == 32) begin
                applyStimulus(1'b0, 16'($urandom), 16'($urandom), 2'b10);
                checkOutput("streamReset", 32'd0);
                applyStimulus(1'b1, 16'd1, 16'd1, 2'b10);
                checkOutput("streamAccZeroed", 32'd1);
            end
            applyStimulus(1'b1, 16'($urandom), 16'($urandom), (i % 2 == 0) ? 2'b00 : 2'b01);
            checkOutput("streamAddMul", modelResult);
        end

        applyStimulus(1'b1, 16'd0, 16'd0, 2'b11);
        for (int i = 0; i < 64; i++) begin
            applyStimulus(($urandom_range(0, 15) != 0), 16'($urandom), 16'($urandom),
                          2'($urandom_range(0, 3)));
            checkOutput("streamMixed", modelResult);
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
